// File: rtl/dmem_mmio_if.sv
// Core data-memory bus plus the output byte stream of dmem_mmio, bundled so
// the core side and the memory/MMIO side see one connection.
interface dmem_mmio_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    modport master (
        output MemWrite, DataAdr, WriteData, out_ready,
        input  ReadData, out_valid, out_data
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, out_ready,
        output ReadData, out_valid, out_data
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data RAM plus a small MMIO page (cycle counter, LED register, byte FIFO)
// for a single-cycle core; loads are combinational, stores land on the edge.
module dmem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    dmem_mmio_if.slave bus,
    output logic [7:0] LEDs
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_CYCLE,
        SEL_LED,
        SEL_TXDATA,
        SEL_TXSTAT
    } sel_e;

    sel_e              sel;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_addr_bits;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel = SEL_NONE;
        if (bus.DataAdr[31:9] == '0) begin
            if (!bus.DataAdr[8]) begin
                sel = SEL_RAM;
            end else if (bus.DataAdr[7:4] == 4'h0) begin
                case (bus.DataAdr[3:2])
                    2'd0:    sel = SEL_CYCLE;
                    2'd1:    sel = SEL_LED;
                    2'd2:    sel = SEL_TXDATA;
                    default: sel = SEL_TXSTAT;
                endcase
            end
        end
    end

    assign ram_idx          = bus.DataAdr[2 +: RAM_AW];
    assign unused_addr_bits = ^bus.DataAdr[1:0];

    // ------------------------------------------------------------------
    // Data RAM
    // ------------------------------------------------------------------
    logic [31:0] ram_q [RAM_WORDS];
    logic        ram_we;

    assign ram_we = bus.MemWrite && !reset && (sel == SEL_RAM);

    // NOTE: the RAM array has no reset; its contents must survive reset and
    // a reset loop over the array would turn it into a huge register file.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= bus.WriteData;
        end
    end

    // ------------------------------------------------------------------
    // MMIO registers and output FIFO
    // ------------------------------------------------------------------
    logic [31:0]      cycle_q, cycle_d;
    logic [7:0]       led_q, led_d;
    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic fifo_full, fifo_empty;
    logic push_req, push_ok, pop, txstat_wr;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && bus.out_ready;
    assign push_req   = bus.MemWrite && (sel == SEL_TXDATA);
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign txstat_wr  = bus.MemWrite && (sel == SEL_TXSTAT);

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        led_d   = led_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        ovf_d   = ovf_q;

        if (bus.MemWrite && (sel == SEL_LED)) begin
            led_d = bus.WriteData[7:0];
        end
        if (push_ok) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (txstat_wr) begin
            ovf_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
            led_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            led_q   <= led_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entries are only meaningful below count, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[tail_q] <= bus.WriteData[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [31:0] txstat;

    assign txstat = {25'd0, ovf_q, fifo_empty, fifo_full, 4'(count_q)};

    always_comb begin
        bus.ReadData = 32'd0;
        case (sel)
            SEL_RAM:    bus.ReadData = ram_q[ram_idx];
            SEL_CYCLE:  bus.ReadData = cycle_q;
            SEL_LED:    bus.ReadData = {24'd0, led_q};
            SEL_TXSTAT: bus.ReadData = txstat;
            default:    bus.ReadData = 32'd0;
        endcase
    end

    assign LEDs          = led_q;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_q[head_q];

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio: RAM, CYCLE, LED, output FIFO
// fill/drain/overflow, asynchronous reset and a backpressure run with a queue model.
module tb_dmem_mmio;

    localparam logic [31:0] A_CYCLE  = 32'h100;
    localparam logic [31:0] A_LED    = 32'h104;
    localparam logic [31:0] A_TXDATA = 32'h108;
    localparam logic [31:0] A_TXSTAT = 32'h10C;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] LEDs;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_mmio_if bus ();

    dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .LEDs  (LEDs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end at a falling edge.
    task automatic wr(input logic [31:0] adr, input logic [31:0] data);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = adr;
        bus.WriteData = data;
        @(negedge clk);
        bus.MemWrite  = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        bus.MemWrite = 1'b0;
        bus.DataAdr  = adr;
        #1;
        check(tag, bus.ReadData, exp);
    endtask

    function automatic logic [31:0] stat(input int sz, input logic ovf);
        logic [3:0] c;
        c = 4'(sz);
        return {25'd0, ovf, (sz == 0), (sz == 4), c};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] drain1 [4];
        logic [7:0] drain2 [4];
        logic [7:0] q [$];
        logic       exp_ovf;
        logic       ready;
        int         sz;
        logic       do_pop;

        drain1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        drain2 = '{8'h22, 8'h33, 8'h44, 8'h66};

        bus.MemWrite  = 1'b0;
        bus.DataAdr   = A_CYCLE;
        bus.WriteData = 32'd0;
        bus.out_ready = 1'b0;
        reset         = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b1;
        #1;
        rd_check("rst_cycle", A_CYCLE, 32'd0);
        check("rst_leds", {24'd0, LEDs}, 32'h0);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        rd_check("rst_txstat", A_TXSTAT, 32'h20);

        // CYCLE counts edges after reset release; writes to it are ignored.
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        rd_check("cycle_10", A_CYCLE, 32'd10);
        wr(A_CYCLE, 32'h0);
        rd_check("cycle_wr_ignored", A_CYCLE, 32'd11);

        // LED register.
        wr(A_LED, 32'h1A5);
        check("led_port", {24'd0, LEDs}, 32'hA5);
        rd_check("led_read", A_LED, 32'h000000A5);

        // RAM, read-during-write, and unmapped decode.
        wr(32'h04, 32'hDEADBEEF);
        wr(32'h44, 32'h12345678);
        rd_check("ram_04", 32'h04, 32'hDEADBEEF);
        rd_check("ram_44", 32'h44, 32'h12345678);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = 32'h04;
        bus.WriteData = 32'hCAFEF00D;
        #1;
        check("ram_rdw_old", bus.ReadData, 32'hDEADBEEF);
        @(negedge clk);
        rd_check("ram_rdw_new", 32'h04, 32'hCAFEF00D);
        wr(32'h04, 32'hDEADBEEF);
        wr(32'h204, 32'h0BADF00D);
        rd_check("unmapped_wr_no_alias", 32'h04, 32'hDEADBEEF);
        rd_check("unmapped_200", 32'h200, 32'h0);
        rd_check("unmapped_110", 32'h110, 32'h0);
        rd_check("unmapped_hi", 32'h8000_0104, 32'h0);

        // FIFO fill, overflow, clear, drain.
        wr(A_TXDATA, 32'h11);
        wr(A_TXDATA, 32'h22);
        wr(A_TXDATA, 32'h33);
        wr(A_TXDATA, 32'h44);
        rd_check("fill_txstat", A_TXSTAT, 32'h14);
        rd_check("txdata_read_zero", A_TXDATA, 32'h0);
        check("fill_head", {24'd0, bus.out_data}, 32'h11);
        wr(A_TXDATA, 32'h55);
        rd_check("ovf_txstat", A_TXSTAT, 32'h54);
        wr(A_TXSTAT, 32'hFFFFFFFF);
        rd_check("ovf_clear", A_TXSTAT, 32'h14);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("drain1_valid", {31'd0, bus.out_valid}, 32'd1);
            check("drain1_data", {24'd0, bus.out_data}, {24'd0, drain1[k]});
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        check("drain1_empty", {31'd0, bus.out_valid}, 32'd0);
        rd_check("drain1_txstat", A_TXSTAT, 32'h20);

        // No bypass: out_valid appears only after the push edge.
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = A_TXDATA;
        bus.WriteData = 32'h11;
        #1;
        check("no_bypass", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        bus.MemWrite = 1'b0;
        check("valid_after_push", {31'd0, bus.out_valid}, 32'd1);
        wr(A_TXDATA, 32'h22);
        wr(A_TXDATA, 32'h33);
        wr(A_TXDATA, 32'h44);

        // Full FIFO with simultaneous push and pop.
        bus.out_ready = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = A_TXDATA;
        bus.WriteData = 32'h66;
        #1;
        check("full_pp_head", {24'd0, bus.out_data}, 32'h11);
        @(negedge clk);
        bus.out_ready = 1'b0;
        rd_check("full_pp_txstat", A_TXSTAT, 32'h14);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("drain2_data", {24'd0, bus.out_data}, {24'd0, drain2[k]});
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        rd_check("drain2_txstat", A_TXSTAT, 32'h20);

        // Reset mid-stream, writes during reset, RAM retention.
        wr(A_TXDATA, 32'hA1);
        wr(A_TXDATA, 32'hA2);
        wr(A_LED, 32'hFF);
        check("pre_rst_leds", {24'd0, LEDs}, 32'hFF);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_leds", {24'd0, LEDs}, 32'h0);
        rd_check("mid_rst_cycle", A_CYCLE, 32'd0);
        rd_check("mid_rst_ram", 32'h04, 32'hDEADBEEF);
        @(negedge clk);
        wr(A_LED, 32'h77);
        wr(32'h04, 32'h11111111);
        wr(A_TXDATA, 32'h99);
        check("rst_wr_led", {24'd0, LEDs}, 32'h0);
        rd_check("rst_wr_ram", 32'h04, 32'hDEADBEEF);
        rd_check("rst_wr_fifo", A_TXSTAT, 32'h20);
        reset = 1'b0;
        @(negedge clk);
        rd_check("first_incr", A_CYCLE, 32'd1);

        // Backpressure: push every cycle, out_ready toggling, queue model.
        exp_ovf = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sz = q.size();
            rd_check("bp_txstat", A_TXSTAT, stat(sz, exp_ovf));
            check("bp_valid", {31'd0, bus.out_valid}, {31'd0, sz != 0});
            if (sz != 0) begin
                check("bp_head", {24'd0, bus.out_data}, {24'd0, q[0]});
            end
            ready         = (i % 2 == 0);
            bus.out_ready = ready;
            bus.MemWrite  = 1'b1;
            bus.DataAdr   = A_TXDATA;
            bus.WriteData = 32'h80 + 32'(i);
            do_pop = ready && (sz != 0);
            if (do_pop) begin
                void'(q.pop_front());
            end
            if (sz < 4 || do_pop) begin
                q.push_back(8'(8'h80 + i));
            end else begin
                exp_ovf = 1'b1;
            end
            @(negedge clk);
        end
        bus.MemWrite  = 1'b0;
        bus.out_ready = 1'b0;
        rd_check("bp_end_txstat", A_TXSTAT, stat(q.size(), exp_ovf));
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8 && q.size() != 0; k++) begin
            #1;
            check("bp_drain", {24'd0, bus.out_data}, {24'd0, q.pop_front()});
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        rd_check("bp_final_txstat", A_TXSTAT, {25'd0, exp_ovf, 6'h20});
        wr(A_TXSTAT, 32'h0);
        rd_check("bp_ovf_cleared", A_TXSTAT, 32'h20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 Parameter RAM_WORDS, default 64: number of 32-bit data RAM words; power of two, at most 64.
REQ-002 Parameter FIFO_DEPTH, default 4: number of entries in the output byte FIFO; power of two, 2..8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MemWrite  input  1  store strobe from the core; one write per cycle while high.
REQ-006 DataAdr  input  32  byte address from the core; bits [1:0] ignored (word access only).
REQ-007 WriteData  input  32  store data.
REQ-008 ReadData  output  32  load data, combinational from DataAdr.
REQ-009 LEDs  output  8  LED register contents.
REQ-010 out_valid  output  1  FIFO head byte available.
REQ-011 out_data  output  8  FIFO head byte.
REQ-012 out_ready  input  1  downstream consumer accepts the head byte.

Function
REQ-013 Decode: DataAdr[31:9] nonzero -> unmapped; DataAdr[8]=0 -> RAM at index DataAdr[7:2] modulo RAM_WORDS; DataAdr[8]=1 with DataAdr[7:4]=0 -> MMIO register at DataAdr[3:2]; any other DataAdr[8]=1 address -> unmapped.
REQ-014 MMIO map: 0x100 CYCLE (RO), 0x104 LED (RW, bits [7:0]), 0x108 TXDATA (WO), 0x10C TXSTAT (RO; a write clears overflow).
REQ-015 Reads are combinational, zero latency, in the same cycle as DataAdr, so a single-cycle core completes a load in one cycle.
REQ-016 Reads of unmapped addresses and of TXDATA return 0x00000000.
REQ-017 LED reads return {24'b0, LED}.
REQ-018 RAM writes take effect at the rising edge while MemWrite=1; a read of the same word in the same cycle returns the old value.
REQ-019 Writes to unmapped addresses and to CYCLE are ignored.
REQ-020 CYCLE is a 32-bit counter that increments by 1 every cycle and wraps from 0xFFFFFFFF to 0x00000000.
REQ-021 A read of CYCLE returns the current register value.
REQ-022 A LED write loads WriteData[7:0]; LEDs is driven directly from the register.
REQ-023 TXSTAT read value: [3:0] = count, [4] = full (count=FIFO_DEPTH), [5] = empty, [6] = overflow; bits [31:7] = 0.
REQ-024 Push: MemWrite=1 at TXDATA writes WriteData[7:0] at the tail.
REQ-025 Push acceptance: a push is accepted when count<FIFO_DEPTH, or when count=FIFO_DEPTH and a pop occurs in the same cycle.
REQ-026 Full-FIFO push: any other push while full is dropped and sets the sticky overflow bit.
REQ-027 Pop occurs when out_valid=1 and out_ready=1 at the rising edge.
REQ-028 out_valid = (count != 0); out_data = head entry; both are driven from registered state only.
REQ-029 Push into an empty FIFO: out_valid rises in the cycle after the push edge; there is no bypass.
REQ-030 Simultaneous push and pop leaves count unchanged; data order is strictly FIFO.
REQ-031 Head and tail pointers wrap modulo FIFO_DEPTH.
REQ-032 out_ready is ignored while out_valid=0.
REQ-033 Writing TXSTAT (any data) clears overflow; if a write to TXSTAT and an overflow event fall in the same cycle, overflow is set (set wins).

Reset
REQ-034 While reset=1, immediately and independent of clk: CYCLE=0, LED=0 (LEDs=0x00), FIFO count=0, pointers=0, overflow=0, out_valid=0.
REQ-035 RAM contents are not reset and are preserved across reset; initial contents are undefined.
REQ-036 Reset asserted mid-operation discards all FIFO contents, including the byte presented on out_data.
REQ-037 The first CYCLE increment occurs at the first rising edge after reset deasserts.
REQ-038 Writes presented while reset=1 have no effect.

Verification
REQ-039 RAM: write 0xDEADBEEF to 0x04, then 0x12345678 to 0x44 (RAM_WORDS=64) -> read 0x04=0xDEADBEEF, 0x44=0x12345678; same-cycle read during write returns the old value; read 0x200 -> 0.
REQ-040 CYCLE/LED: deassert reset, wait 10 edges -> CYCLE=10; write 0x1A5 to 0x104 -> LEDs=0xA5, read=0x000000A5; write CYCLE -> value unaffected.
REQ-041 FIFO fill: out_ready=0, push 0x11,0x22,0x33,0x44 -> TXSTAT=0x14; fifth push 0x55 -> TXSTAT=0x54; write TXSTAT -> 0x14; drain with out_ready=1 -> 0x11,0x22,0x33,0x44 on consecutive cycles, then TXSTAT=0x20.
REQ-042 Full with simultaneous push+pop: full FIFO, out_ready=1, push 0x66 -> 0x11 popped, count stays 4, overflow=0, 0x66 emerges last.
REQ-043 Reset mid-stream: two bytes queued, LED=0xFF, assert reset between edges -> out_valid=0, LEDs=0x00, CYCLE=0 without a clock edge; RAM word 0x04 still 0xDEADBEEF.
REQ-044 Backpressure: push every cycle for 20 cycles with out_ready toggling 1/0 -> accepted bytes appear in order with none duplicated; overflow is set exactly when a push meets a full FIFO with no pop.
